// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, and an optional
// 2-entry skid buffer. Define PIPE_PERF_CNT_EN to add stall/flush event counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occ_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] skid_p0;
  logic              rdy_p0;
  logic              up_fire;
  logic              dn_fire;

  assign dn_valid_o = (state_p0 != EMPTY);
  assign dn_data_o  = data_p0;
  assign occ_o      = state_p0;
  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = dn_valid_o & dn_ready_i;

  // Skid mode registers ready so downstream back-pressure never reaches upstream combinationally.
  if (SKID_EN) begin : g_skid_ready
    assign up_ready_o = rdy_p0;
  end else begin : g_comb_ready
    assign up_ready_o = ~dn_valid_o | dn_ready_i;
  end

  // ---- stage p0: state, head and skid registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      data_p0  <= FLUSH_VAL;
      skid_p0  <= FLUSH_VAL;
      rdy_p0   <= 1'b1;
    end else if (flush_i) begin
      state_p0 <= EMPTY;
      data_p0  <= FLUSH_VAL;
      skid_p0  <= FLUSH_VAL;
      rdy_p0   <= 1'b1;
    end else begin
      case (state_p0)
        EMPTY: begin
          rdy_p0 <= 1'b1;
          if (up_fire) begin
            state_p0 <= ONE;
            data_p0  <= up_data_i;
          end
        end
        ONE: begin
          rdy_p0 <= 1'b1;
          if (up_fire && dn_fire) begin
            data_p0 <= up_data_i;
          end else if (up_fire) begin
            // Only reachable in skid mode; combinational ready forbids it otherwise.
            if (SKID_EN) begin
              state_p0 <= FULL;
              skid_p0  <= up_data_i;
              rdy_p0   <= 1'b0;
            end
          end else if (dn_fire) begin
            state_p0 <= EMPTY;
          end
        end
        FULL: begin
          rdy_p0 <= 1'b0;
          if (dn_fire) begin
            state_p0 <= ONE;
            data_p0  <= skid_p0;
            skid_p0  <= FLUSH_VAL;
            rdy_p0   <= 1'b1;
          end
        end
        default: begin
          state_p0 <= EMPTY;
          rdy_p0   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Event counters wrap naturally and ignore flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (dn_valid_o && !dn_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (state_p0 != EMPTY)) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: one skid-mode and one single-entry instance.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam logic [DW-1:0] FV = 16'h0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // skid instance (k_) and single-entry instance (s_)
  logic          k_flush, k_uv, k_ur, k_dv, k_dr;
  logic [DW-1:0] k_ud, k_dd;
  logic [1:0]    k_occ;
  logic          s_flush, s_uv, s_ur, s_dv, s_dr;
  logic [DW-1:0] s_ud, s_dd;
  logic [1:0]    s_occ;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] k_stall, k_fcnt, s_stall, s_fcnt;
`endif

  int total  = 0;
  int passed = 0;

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID_EN(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush_i(k_flush),
    .up_valid_i(k_uv), .up_ready_o(k_ur), .up_data_i(k_ud),
    .dn_valid_o(k_dv), .dn_ready_i(k_dr), .dn_data_o(k_dd), .occ_o(k_occ)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt_o(k_stall), .flush_cnt_o(k_fcnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .SKID_EN(1'b0)) u_single (
    .clk(clk), .rst(rst), .flush_i(s_flush),
    .up_valid_i(s_uv), .up_ready_o(s_ur), .up_data_i(s_ud),
    .dn_valid_o(s_dv), .dn_ready_i(s_dr), .dn_data_o(s_dd), .occ_o(s_occ)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt_o(s_stall), .flush_cnt_o(s_fcnt)
`endif
  );

  // Observed state packed as {dn_valid, occ, up_ready, dn_data}
  function automatic logic [19:0] kst();
    return {k_dv, k_occ, k_ur, k_dd};
  endfunction
  function automatic logic [19:0] sst();
    return {s_dv, s_occ, s_ur, s_dd};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    k_flush = 1'b0; k_uv = 1'b0; k_dr = 1'b0; k_ud = '0;
    s_flush = 1'b0; s_uv = 1'b0; s_dr = 1'b0; s_ud = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    total++;
    if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL reset_skid: got %h expected %h", kst(), {1'b0, 2'd0, 1'b1, FV});
    else passed++;
    total++;
    if ({s_dv, s_occ, s_dd} !== {1'b0, 2'd0, FV}) $display("FAIL reset_single: got %h expected %h", {s_dv, s_occ, s_dd}, {1'b0, 2'd0, FV});
    else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL reset_release: got %h expected %h", kst(), {1'b0, 2'd0, 1'b1, FV});
    else passed++;
  endtask

  task automatic test_streaming();
    k_dr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      k_uv = 1'b1;
      k_ud = DW'(i);
      tick();
      total++;
      if (kst() !== {1'b1, 2'd1, 1'b1, DW'(i)}) $display("FAIL stream_%0d: got %h expected %h", i, kst(), {1'b1, 2'd1, 1'b1, DW'(i)});
      else passed++;
    end
    k_uv = 1'b0;
    tick();
    total++;
    if ({k_dv, k_occ} !== 3'b000) $display("FAIL stream_drain: got %b expected %b", {k_dv, k_occ}, 3'b000);
    else passed++;
  endtask

  task automatic test_back_pressure();
    k_dr = 1'b0; k_uv = 1'b1; k_ud = 16'h000A;
    tick();
    total++;
    if (kst() !== {1'b1, 2'd1, 1'b1, 16'h000A}) $display("FAIL bp_first: got %h expected %h", kst(), {1'b1, 2'd1, 1'b1, 16'h000A});
    else passed++;
    k_ud = 16'h000B;
    tick();
    total++;
    if (kst() !== {1'b1, 2'd2, 1'b0, 16'h000A}) $display("FAIL bp_full: got %h expected %h", kst(), {1'b1, 2'd2, 1'b0, 16'h000A});
    else passed++;
    k_ud = 16'h00EE;
    tick();
    total++;
    if (kst() !== {1'b1, 2'd2, 1'b0, 16'h000A}) $display("FAIL bp_hold: got %h expected %h", kst(), {1'b1, 2'd2, 1'b0, 16'h000A});
    else passed++;
    k_uv = 1'b0; k_dr = 1'b1;
    tick();
    total++;
    if (kst() !== {1'b1, 2'd1, 1'b1, 16'h000B}) $display("FAIL bp_second: got %h expected %h", kst(), {1'b1, 2'd1, 1'b1, 16'h000B});
    else passed++;
    tick();
    total++;
    if ({k_dv, k_occ, k_ur} !== 4'b0001) $display("FAIL bp_empty: got %b expected %b", {k_dv, k_occ, k_ur}, 4'b0001);
    else passed++;
  endtask

  task automatic test_flush();
    k_dr = 1'b0; k_uv = 1'b1; k_ud = 16'h0001;
    tick();
    k_ud = 16'h0002;
    tick();
    total++;
    if (k_occ !== 2'd2) $display("FAIL flush_fill: got %0d expected %0d", k_occ, 2);
    else passed++;
    k_flush = 1'b1; k_ud = 16'h000C;
    tick();
    total++;
    if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL flush_full: got %h expected %h", kst(), {1'b0, 2'd0, 1'b1, FV});
    else passed++;
    // Held flush keeps dropping accepted input.
    k_ud = 16'h000D;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL flush_held_%0d: got %h expected %h", i, kst(), {1'b0, 2'd0, 1'b1, FV});
      else passed++;
    end
    k_flush = 1'b0; k_uv = 1'b0; k_dr = 1'b1;
    tick();
    total++;
    if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL flush_after: got %h expected %h", kst(), {1'b0, 2'd0, 1'b1, FV});
    else passed++;
  endtask

  task automatic test_async_reset();
    k_dr = 1'b0; k_uv = 1'b1; k_ud = 16'h0021;
    tick();
    k_ud = 16'h0022;
    tick();
    k_uv = 1'b0;
    total++;
    if (k_occ !== 2'd2) $display("FAIL areset_fill: got %0d expected %0d", k_occ, 2);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (kst() !== {1'b0, 2'd0, 1'b1, FV}) $display("FAIL areset_async: got %h expected %h", kst(), {1'b0, 2'd0, 1'b1, FV});
    else passed++;
    tick();
    rst = 1'b0;
    k_dr = 1'b1; k_uv = 1'b1; k_ud = 16'h0005;
    tick();
    total++;
    if (kst() !== {1'b1, 2'd1, 1'b1, 16'h0005}) $display("FAIL areset_resume: got %h expected %h", kst(), {1'b1, 2'd1, 1'b1, 16'h0005});
    else passed++;
    k_uv = 1'b0;
    tick();
    total++;
    if ({k_dv, k_occ} !== 3'b000) $display("FAIL areset_alone: got %b expected %b", {k_dv, k_occ}, 3'b000);
    else passed++;
  endtask

  task automatic test_single_entry();
    s_dr = 1'b0; s_uv = 1'b1; s_ud = 16'h0003;
    tick();
    s_ud = 16'h0009;
    #1;
    total++;
    if (sst() !== {1'b1, 2'd1, 1'b0, 16'h0003}) $display("FAIL single_blocked: got %h expected %h", sst(), {1'b1, 2'd1, 1'b0, 16'h0003});
    else passed++;
    tick();
    total++;
    if (sst() !== {1'b1, 2'd1, 1'b0, 16'h0003}) $display("FAIL single_hold: got %h expected %h", sst(), {1'b1, 2'd1, 1'b0, 16'h0003});
    else passed++;
    s_dr = 1'b1; s_ud = 16'h0007;
    #1;
    total++;
    if (s_ur !== 1'b1) $display("FAIL single_comb_ready: got %b expected %b", s_ur, 1'b1);
    else passed++;
    tick();
    total++;
    if (sst() !== {1'b1, 2'd1, 1'b1, 16'h0007}) $display("FAIL single_replace: got %h expected %h", sst(), {1'b1, 2'd1, 1'b1, 16'h0007});
    else passed++;
    s_uv = 1'b0;
    tick();
    s_dr = 1'b0;
    #1;
    total++;
    if ({s_dv, s_occ, s_ur} !== 4'b0001) $display("FAIL single_empty: got %b expected %b", {s_dv, s_occ, s_ur}, 4'b0001);
    else passed++;
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_counters();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    k_uv = 1'b1; k_ud = 16'h0031;
    tick();
    k_uv = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (k_stall !== 32'd3) $display("FAIL perf_stall: got %0d expected %0d", k_stall, 3);
    else passed++;
    k_dr = 1'b1; k_flush = 1'b1;
    tick();
    total++;
    if ({k_stall, k_fcnt} !== {32'd3, 32'd1}) $display("FAIL perf_flush: got %h expected %h", {k_stall, k_fcnt}, {32'd3, 32'd1});
    else passed++;
    tick();
    k_flush = 1'b0;
    total++;
    if (k_fcnt !== 32'd1) $display("FAIL perf_flush_empty: got %0d expected %0d", k_fcnt, 1);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_single_entry();
`ifdef PIPE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic pipeline stage register that replaces the fixed per-field flush-only stage registers between CPU pipeline stages (e.g. ID→EX).
- Carries one packed payload of DATA_W bits with a valid/ready handshake on each side.
- Synchronous flush (jump/branch kill) loads FLUSH_VAL.
- Optional 2-entry skid buffer gives full throughput with a registered up_ready_o, so back-pressure is not a combinational path through the stage.

Parameters:
- DATA_W, 64: payload width in bits (packed inst/addr/operands/rd/wen).
- FLUSH_VAL, {DATA_W{1'b0}}: payload value loaded on reset or flush (set to NOP encoding in the inst field).
- SKID_EN, 1: 1 = 2-entry skid mode with registered ready; 0 = single-entry mode with combinational ready.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  kill all held entries (jump/branch taken)
- up_valid_i  in  1  upstream payload valid
- up_ready_o  out  1  stage can accept; up fire = up_valid_i & up_ready_o
- up_data_i  in  DATA_W  upstream payload
- dn_valid_o  out  1  stage holds a valid payload
- dn_ready_i  in  1  downstream accepts; dn fire = dn_valid_o & dn_ready_i
- dn_data_o  out  DATA_W  head payload (main register)
- occ_o  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset (asynchronous, while rst=1):
  - state EMPTY; main and skid registers = FLUSH_VAL.
  - dn_valid_o=0, occ_o=0, dn_data_o=FLUSH_VAL.
  - up_ready_o=1 in SKID_EN=1 mode.
- Latency: 1 cycle. up fire at edge N → dn_valid_o=1 with that data after edge N.
- dn_data_o is always the main register. It is stable while dn_valid_o=1 and dn_ready_i=0.
- SKID_EN=1 states (encoded by occ_o):
  - EMPTY: up fire → ONE, main<=up_data_i.
  - ONE:
    - up fire and dn fire → ONE, main<=up_data_i.
    - up fire only → FULL, skid<=up_data_i.
    - dn fire only → EMPTY.
    - neither → hold.
  - FULL: up_ready_o=0, so up_valid_i is ignored. dn fire → ONE, main<=skid, skid<=FLUSH_VAL.
  - up_ready_o is a flop, set to 1 whenever the next state is not FULL. Because it is registered, FULL is entered only via the ONE → FULL path.
- SKID_EN=0:
  - No skid register; occ_o never exceeds 1.
  - up_ready_o = ~dn_valid_o | dn_ready_i (combinational).
  - Transitions are the same as EMPTY/ONE above.
- Flush:
  - flush_i has highest priority over all handshakes in the same cycle.
  - Next state is EMPTY; main and skid <= FLUSH_VAL.
  - An up fire coinciding with flush_i is consumed and dropped.
  - A dn fire coinciding with flush_i still completes downstream, because the data was already presented.
  - up_ready_o=1 after the flush edge.
- Flush held for multiple cycles: the stage stays EMPTY and keeps dropping input.
- rst asserted mid-transfer: any entry is lost immediately, and outputs go to their reset values asynchronously.
- Order is strictly FIFO: skid contents never overtake main.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - stall_cnt_o (32): increments each cycle with dn_valid_o=1 and dn_ready_i=0.
  - flush_cnt_o (32): increments each cycle with flush_i=1 and occ_o≠0.
- Both counters wrap modulo 2^32, reset to 0 on rst, and are unaffected by flush.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Streaming: SKID_EN=1, dn_ready_i=1, up_valid_i=1 with data 1,2,3,4 on consecutive cycles → dn_data_o shows 1,2,3,4 one cycle later, one per cycle, with occ_o=1 throughout.
- Back-pressure: SKID_EN=1, send 0xA then 0xB while dn_ready_i=0 → occ_o=2 and up_ready_o=0 the next cycle, dn_data_o=0xA held. Then raise dn_ready_i → 0xA, then 0xB, then dn_valid_o=0.
- Flush: in FULL state, assert flush_i together with up_valid_i carrying 0xC → next cycle occ_o=0, dn_valid_o=0, dn_data_o=FLUSH_VAL, up_ready_o=1, and 0xC never appears.
- Async reset: assert rst mid-cycle with occ_o=2 → outputs go to their reset values before the next edge. After release, 0x5 sent is output alone.
- SKID_EN=0: dn_ready_i=0 with one entry held → up_ready_o=0. Raise dn_ready_i with up_valid_i=1, data 0x7 → up_ready_o=1 in the same cycle, and 0x7 replaces the head next cycle.
- PIPE_PERF_CNT_EN: 3 stall cycles followed by one flush with an entry held → stall_cnt_o=3, flush_cnt_o=1.
